// File: rtl/cmp_unit_seq.sv
// cmp_unit_seq: chunked sequential SLT/SLTU comparator with optional branch conditions (define CMP_BRANCH_EN)
module cmp_unit_seq #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [6:0]      opcode,
  input  logic [2:0]      func3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Y,
  output logic            taken,
  output logic            busy
);
  localparam int NCHUNK = XLEN / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] a_r, b_r;
  logic [6:0] op_r;
  logic [2:0] f3_r;
  logic [IW-1:0] idx;
  logic [CHUNK-1:0] flip, ca, cb;
  logic sgn, ceq, clt, last, alu, y_bit, y_r;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign Y = XLEN'(y_r);
  // current chunk compare; the sign bit is flipped on the top chunk of signed ops so an unsigned compare orders it correctly
  always_comb begin
    sgn = f3_r == 3'b010 || f3_r[2:1] == 2'b10;
    flip = (sgn && idx == IW'(NCHUNK - 1)) ? CHUNK'(1) << (CHUNK - 1) : '0;
    ca = a_r[idx*CHUNK +: CHUNK] ^ flip;
    cb = b_r[idx*CHUNK +: CHUNK] ^ flip;
    ceq = ca == cb;
    clt = ca < cb;
    last = !ceq || idx == '0;
    alu = op_r == 7'b0110011 || op_r == 7'b0010011;
    y_bit = alu && f3_r[2:1] == 2'b01 && clt;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // next state: accept, scan chunks until a difference or the last chunk, then hold until consumed
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? CMP : IDLE) :
              state == CMP  ? (last ? DONE : CMP) :
                              (out_ready ? IDLE : DONE);
  end
`ifdef CMP_BRANCH_EN
  logic t_bit, t_r;
  assign taken = t_r;
  // branch condition: bit 2 selects lt vs eq, bit 0 inverts it; func3 010/011 are not branches
  always_comb begin
    t_bit = op_r == 7'b1100011 && (f3_r[2] || !f3_r[1]) && (f3_r[2] ? f3_r[0] ^ clt : f3_r[0] ^ ceq);
  end
`else
  assign taken = 1'b0;
`endif
  // operand capture, chunk index walk and result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      y_r <= 1'b0;
`ifdef CMP_BRANCH_EN
      t_r <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      a_r <= A;
      b_r <= B;
      op_r <= opcode;
      f3_r <= func3;
      idx <= IW'(NCHUNK - 1);
    end else if (state == CMP) begin
      if (last) begin
        y_r <= y_bit;
`ifdef CMP_BRANCH_EN
        t_r <= t_bit;
`endif
      end else idx <= idx - IW'(1);
    end
  end
endmodule

// File: tb/tb_cmp_unit_seq.sv
// tb_cmp_unit_seq: directed vectors with literal expectations plus a per-cycle check against an arithmetic model
module tb_cmp_unit_seq;
  localparam int XLEN = 32;
  localparam int CHUNK = 8;
  localparam int NCHUNK = XLEN / CHUNK;
  logic clk = 0, rst, in_valid, in_ready, out_valid, out_ready, taken, busy;
  logic [XLEN-1:0] A, B, Y;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic exp_y, exp_t;
  int checks = 0, failures = 0;
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [31:0] a;
    logic [31:0] b;
    logic y;
    logic tb;
    int lat;
    int hold;
  } vec_t;
  vec_t v[$];

  cmp_unit_seq #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .func3(func3),
    .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .taken(taken), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, output logic y, output logic t, output int lat);
    logic [31:0] x;
    x = a ^ b;
    lat = NCHUNK;
    for (int i = XLEN - 1; i >= 0; i--)
      if (x[i]) begin
        lat = NCHUNK - i / CHUNK;
        break;
      end
    y = (op == 7'b0110011 || op == 7'b0010011) &&
        ((f3 == 3'b010 && $signed(a) < $signed(b)) || (f3 == 3'b011 && a < b));
    t = 1'b0;
`ifdef CMP_BRANCH_EN
    if (op == 7'b1100011)
      case (f3)
        3'b000: t = a == b;
        3'b001: t = a != b;
        3'b100: t = $signed(a) < $signed(b);
        3'b101: t = $signed(a) >= $signed(b);
        3'b110: t = a < b;
        3'b111: t = a >= b;
        default: t = 1'b0;
      endcase
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        chk("cmp_Y", Y, {31'b0, exp_y});
        chk("cmp_taken", taken, exp_t);
      end
      chk("cmp_busy", busy, !in_ready);
    end
  end

  task automatic run(input vec_t t);
    logic my, mt;
    int ml, lat;
    logic lit_t;
    model(t.op, t.f3, t.a, t.b, my, mt, ml);
`ifdef CMP_BRANCH_EN
    lit_t = t.tb;
`else
    lit_t = 1'b0;
`endif
    exp_y = my;
    exp_t = mt;
    opcode = t.op; func3 = t.f3; A = t.a; B = t.b;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("lat_literal", lat, t.lat);
    chk("lat_model", lat, ml);
    chk("Y_literal", Y, {31'b0, t.y});
    chk("taken_literal", taken, lit_t);
    repeat (t.hold) begin
      in_valid = 1; opcode = 7'b0110011; func3 = 3'b010; A = 32'd0; B = 32'd1;
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_out_valid", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    in_valid = 0;
    chk("post_in_ready", in_ready, 1'b1);
    chk("post_out_valid", out_valid, 1'b0);
    chk("post_busy", busy, 1'b0);
  endtask

  initial begin
    rst = 1; in_valid = 0; out_ready = 0; A = '0; B = '0; opcode = '0; func3 = '0;
    exp_y = 0; exp_t = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_Y", Y, 32'd0);
    chk("rst_taken", taken, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 0;
    v.push_back('{7'b0110011, 3'b010, 32'hFFFFFFFB, 32'd10, 1'b1, 1'b0, 1, 0});
    v.push_back('{7'b0110011, 3'b011, 32'd5, 32'd10, 1'b1, 1'b0, 4, 0});
    v.push_back('{7'b0110011, 3'b011, 32'hFFFFFFFF, 32'd10, 1'b0, 1'b0, 1, 0});
    v.push_back('{7'b0010011, 3'b010, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0, 1'b0, 4, 0});
    v.push_back('{7'b0010011, 3'b011, 32'd2, 32'd10, 1'b1, 1'b0, 4, 5});
    v.push_back('{7'b1100011, 3'b111, 32'h80000000, 32'd1, 1'b0, 1'b1, 1, 0});
    v.push_back('{7'b1100011, 3'b101, 32'h80000000, 32'd1, 1'b0, 1'b0, 1, 0});
    v.push_back('{7'b1100011, 3'b000, 32'h12345678, 32'h12345678, 1'b0, 1'b1, 4, 0});
    v.push_back('{7'b1100011, 3'b001, 32'h12345678, 32'h12345679, 1'b0, 1'b1, 4, 0});
    v.push_back('{7'b1100011, 3'b100, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 1, 0});
    v.push_back('{7'b1100011, 3'b110, 32'h00010000, 32'h00020000, 1'b0, 1'b1, 2, 1});
    v.push_back('{7'b0110011, 3'b000, 32'd1, 32'd2, 1'b0, 1'b0, 4, 0});
    v.push_back('{7'b1100011, 3'b010, 32'd1, 32'd2, 1'b0, 1'b0, 4, 0});
    v.push_back('{7'b0110011, 3'b010, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, 1, 0});
    v.push_back('{7'b0110011, 3'b010, 32'h00FF0000, 32'h00800000, 1'b0, 1'b0, 2, 0});
    foreach (v[i]) run(v[i]);
    exp_y = 1; exp_t = 0;
    opcode = 7'b0110011; func3 = 3'b011; A = 32'd5; B = 32'd10;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    chk("mid_busy", busy, 1'b1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_Y", Y, 32'd0);
    chk("abort_taken", taken, 1'b0);
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort_no_result", out_valid, 1'b0);
    end
    run('{7'b0110011, 3'b010, 32'd15, 32'hFFFFFFFD, 1'b0, 1'b0, 1, 0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cmp_unit_seq.md
CMP_UNIT_SEQ -- requirements
Module: cmp_unit_seq

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning operand and result width in bits.
REQ-002 The module SHALL have parameter CHUNK, default 8, meaning bits compared per cycle; XLEN SHALL be an integer multiple of CHUNK, and NCHUNK = XLEN/CHUNK.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit, meaning the request fields are valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit, meaning the unit can accept a request.
REQ-007 The module SHALL have port A, input, XLEN bits, meaning rs1.
REQ-008 The module SHALL have port B, input, XLEN bits, meaning rs2 or an immediate already sign-extended externally.
REQ-009 The module SHALL have port opcode, input, 7 bits, meaning instruction[6:0].
REQ-010 The module SHALL have port func3, input, 3 bits, meaning instruction[14:12].
REQ-011 The module SHALL have port out_valid, output, 1 bit, meaning Y and taken hold a completed result.
REQ-012 The module SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-013 The module SHALL have port Y, output, XLEN bits, meaning the set-less-than result, 0 or 1 zero-extended.
REQ-014 The module SHALL have port taken, output, 1 bit, meaning the branch condition result.
REQ-015 The module SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-016 The module SHALL implement FSM states IDLE, CMP and DONE; in_ready = (state==IDLE).
REQ-017 When in_valid&&in_ready at a clock edge, the module SHALL register A, B, opcode and func3, load chunk index NCHUNK-1, and enter CMP.
REQ-018 In each CMP cycle the module SHALL compare chunk i (bits i*CHUNK+CHUNK-1 : i*CHUNK) of the captured operands, recording eq/lt for that chunk.
REQ-019 For signed operations on chunk NCHUNK-1, the module SHALL invert the MSB of both chunks before an unsigned chunk compare; all other chunks SHALL compare unsigned.
REQ-020 If the chunks differ, or i==0, the module SHALL latch the final eq/lt and enter DONE at that edge; otherwise it SHALL decrement i and remain in CMP.
REQ-021 Latency from the accept edge to out_valid high SHALL be k cycles, where k is the number of chunks examined (1..NCHUNK), stopping at the first differing chunk from the MSB; for equal operands k=NCHUNK.
REQ-022 With opcode 0110011 or 0010011, func3 010 SHALL give signed A<B and func3 011 SHALL give unsigned A<B in Y[0]; Y[XLEN-1:1]=0 and taken=0.
REQ-023 Any unsupported opcode/func3 pair SHALL still take the full compare path and SHALL return Y=0 and taken=0.
REQ-024 In DONE, out_valid SHALL be 1 and Y/taken SHALL stay stable while out_ready=0; on out_valid&&out_ready the module SHALL return to IDLE.
REQ-025 A new request SHALL NOT be accepted in the cycle the result is consumed; in_ready rises the next cycle.

Reset
REQ-026 While rst=1 at an edge, the module SHALL go to IDLE with out_valid=0, Y=0, taken=0, busy=0, in_ready=1, and chunk index=0.
REQ-027 Reset asserted during CMP or DONE SHALL discard the operation with no result presented.

Configuration
REQ-028 With macro CMP_BRANCH_EN defined, opcode 1100011 SHALL be supported: func3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU and 111 BGEU SHALL drive taken; Y=0; BLT/BGE SHALL be signed.
REQ-029 Without CMP_BRANCH_EN, opcode 1100011 SHALL be unsupported per REQ-023, and taken SHALL be constant 0.

Verification
REQ-030 XLEN=32, CHUNK=8: SLT with A=-5, B=10 -> Y=1 and out_valid 1 cycle after accept, since the MSB chunk differs.
REQ-031 SLTU with A=5, B=10 -> Y=1 after 4 cycles; SLTU with A=0xFFFFFFFF, B=10 -> Y=0 after 1 cycle.
REQ-032 SLTI with A=-4, B=-4 -> Y=0 after 4 cycles (all chunks equal).
REQ-033 SLTIU with A=2, B=10 and out_ready=0 for 5 cycles -> Y=1 held stable, in_ready=0, and a request presented meanwhile is not accepted.
REQ-034 With CMP_BRANCH_EN: BGEU with A=0x80000000, B=1 -> taken=1; BGE with the same operands -> taken=0; without the macro both -> taken=0.
REQ-035 rst pulsed during the 2nd CMP cycle of an SLTU -> no out_valid, in_ready=1 next cycle; a following SLT with A=15, B=-3 -> Y=0.
